// File: rtl/poly_basemul_ctrl_pkg.sv
// Shared constants and FSM encoding for the pointwise Montgomery multiply controller.
// Holds the Kyber modulus, the Montgomery constants and the controller state type.
package poly_basemul_ctrl_pkg;

    localparam int KYBER_Q     = 3329;
    localparam int KYBER_N     = 256;
    localparam int R_MOD_Q     = 2285;   // 2^16 mod Q
    localparam int R2_MOD_Q    = 1353;   // 2^32 mod Q
    localparam int R_INV_MOD_Q = 169;    // 2^-16 mod Q

    // Q^-1 mod 2^16, used to cancel the low half of the product.
    localparam logic [15:0] QINV = 16'd62209;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } state_t;

endpackage

// File: rtl/poly_basemul_ctrl_montgomery_mul.sv
// Combinational Montgomery multiply: r = a*b*2^-16 mod Q, fully reduced to [0, Q-1].
// Valid for signed 16-bit operands with |a*b| < Q*2^15.
module poly_basemul_ctrl_montgomery_mul
    import poly_basemul_ctrl_pkg::*;
(
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output logic        [15:0] o_r
);

    localparam logic signed [15:0] Q16 = 16'(KYBER_Q);

    logic signed [31:0] w_a_ext;
    logic signed [31:0] w_b_ext;
    logic signed [31:0] w_prod;
    logic        [15:0] w_t;
    logic signed [31:0] w_t_ext;
    logic signed [31:0] w_tq;
    logic signed [31:0] w_u;
    logic signed [15:0] w_r;

    assign w_a_ext = 32'(i_a);
    assign w_b_ext = 32'(i_b);
    assign w_prod  = w_a_ext * w_b_ext;

    // t*Q matches the product in its low 16 bits, so w_u is an exact multiple of 2^16.
    assign w_t     = w_prod[15:0] * QINV;
    assign w_t_ext = 32'($signed(w_t));
    assign w_tq    = w_t_ext * KYBER_Q;
    assign w_u     = w_prod - w_tq;
    assign w_r     = 16'(w_u >>> 16);

    // w_r lies in (-Q, Q); one conditional add gives the canonical residue.
    assign o_r = w_r[15] ? w_r + Q16 : w_r;

endmodule

// File: rtl/poly_basemul_ctrl.sv
// Streams N coefficient pairs from RAMs A and B through one Montgomery multiplier
// into RAM C at one coefficient per cycle, with start/abort/done handshake.
module poly_basemul_ctrl
    import poly_basemul_ctrl_pkg::*;
#(
    parameter int N      = KYBER_N,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    output logic                     busy,
    output logic                     done,
    output logic                     a_rd_en,
    output logic [ADDR_W-1:0]        a_addr,
    input  logic signed [15:0]       a_rdata,
    output logic                     b_rd_en,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic signed [15:0]       b_rdata,
    output logic                     c_we,
    output logic [ADDR_W-1:0]        c_addr,
    output logic [15:0]              c_wdata
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    generate
        if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
            $error("poly_basemul_ctrl: RD_LAT must be in 1..3");
        end
    endgenerate

    state_t              r_state;
    state_t              w_next;
    logic                r_busy;
    logic                r_done;
    logic                r_rd_en;
    logic [ADDR_W-1:0]   r_addr;
    logic [RD_LAT-1:0]   r_vld;
    logic [ADDR_W-1:0]   r_vaddr [RD_LAT];
    logic                r_c_we;
    logic [ADDR_W-1:0]   r_c_addr;
    logic [15:0]         r_c_wdata;
    logic [15:0]         w_mul;
    logic                w_flush;

    poly_basemul_ctrl_montgomery_mul u_montgomery_mul (
        .i_a (a_rdata),
        .i_b (b_rdata),
        .o_r (w_mul)
    );

    assign w_flush = abort && (r_state == ST_ISSUE || r_state == ST_DRAIN);

    always_comb begin
        // NOTE: default assigned first so every path drives w_next and no latch is inferred.
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start && !abort)               w_next = ST_ISSUE;
            ST_ISSUE: if (abort)                         w_next = ST_IDLE;
                      else if (r_addr == LAST_IDX)       w_next = ST_DRAIN;
            ST_DRAIN: if (abort)                         w_next = ST_IDLE;
                      else if (r_c_we && r_c_addr == LAST_IDX) w_next = ST_FIN;
            ST_FIN:                                      w_next = ST_IDLE;
            default:                                     w_next = ST_IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they appear registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_addr  <= '0;
        end else begin
            // NOTE: state updates use non-blocking assignments so all flops sample the same edge.
            r_state <= w_next;
            r_busy  <= (w_next == ST_ISSUE) || (w_next == ST_DRAIN);
            r_done  <= (w_next == ST_FIN);
            r_rd_en <= (w_next == ST_ISSUE);
            r_addr  <= (w_next == ST_ISSUE && r_state == ST_ISSUE) ? r_addr + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= '0;
            // NOTE: the address shift register is only RD_LAT deep, so it is reset with the valid bits.
            for (int k = 0; k < RD_LAT; k++) r_vaddr[k] <= '0;
            r_c_we    <= 1'b0;
            r_c_addr  <= '0;
            r_c_wdata <= '0;
        end else begin
            r_vld[0]   <= r_rd_en && !w_flush;
            r_vaddr[0] <= r_addr;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k]   <= r_vld[k-1] && !w_flush;
                r_vaddr[k] <= r_vaddr[k-1];
            end
            r_c_we <= r_vld[RD_LAT-1] && !w_flush;
            if (r_vld[RD_LAT-1] && !w_flush) begin
                r_c_addr  <= r_vaddr[RD_LAT-1];
                r_c_wdata <= w_mul;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign a_rd_en = r_rd_en;
    assign b_rd_en = r_rd_en;
    assign a_addr  = r_addr;
    assign b_addr  = r_addr;
    assign c_we    = r_c_we;
    assign c_addr  = r_c_addr;
    assign c_wdata = r_c_wdata;

endmodule

// File: tb/tb_poly_basemul_ctrl.sv
// Bench for poly_basemul_ctrl: three instances (RD_LAT = 1, 2, 3) share stimulus and RAM contents,
// each with its own read-latency RAM model and write monitor.
module tb_poly_basemul_ctrl;
    import poly_basemul_ctrl_pkg::*;

    localparam int NL = 3;
    localparam int NC = 256;

    typedef struct {
        int a;
        int b;
        int c;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic                 abort;
    logic [NL-1:0]        busy_v, done_v, a_rd_en_v, b_rd_en_v, c_we_v;
    logic [NL-1:0][7:0]   a_addr_v, b_addr_v, c_addr_v;
    logic [NL-1:0][15:0]  c_wdata_v;
    logic signed [15:0]   ra_pipe [NL][3];
    logic signed [15:0]   rb_pipe [NL][3];

    logic signed [15:0]   mem_a [NC];
    logic signed [15:0]   mem_b [NC];
    int                   expc  [NC];
    logic [15:0]          cres  [NL][NC];
    vec_t                 vecs  [16];

    int n_vec = 0;
    int n_err = 0;
    int edge_cnt = 0;
    int e0 = 0;
    bit clr_mon;
    int wr_cnt [NL];
    int addr_err [NL];
    int done_cnt [NL];
    int done_cyc [NL];
    int busy_cnt [NL];
    int snap [NL];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NL; g++) begin : g_dut
        poly_basemul_ctrl #(.N(NC), .ADDR_W(8), .RD_LAT(g + 1)) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start),
            .abort   (abort),
            .busy    (busy_v[g]),
            .done    (done_v[g]),
            .a_rd_en (a_rd_en_v[g]),
            .a_addr  (a_addr_v[g]),
            .a_rdata (ra_pipe[g][g]),
            .b_rd_en (b_rd_en_v[g]),
            .b_addr  (b_addr_v[g]),
            .b_rdata (rb_pipe[g][g]),
            .c_we    (c_we_v[g]),
            .c_addr  (c_addr_v[g]),
            .c_wdata (c_wdata_v[g])
        );
    end

    // RAM read model: data appears g+1 cycles after the read enable of instance g.
    always @(posedge clk) begin
        edge_cnt <= edge_cnt + 1;
        for (int g = 0; g < NL; g++) begin
            ra_pipe[g][0] <= a_rd_en_v[g] ? mem_a[a_addr_v[g]] : 16'sd0;
            rb_pipe[g][0] <= b_rd_en_v[g] ? mem_b[b_addr_v[g]] : 16'sd0;
            for (int s = 1; s < 3; s++) begin
                ra_pipe[g][s] <= ra_pipe[g][s-1];
                rb_pipe[g][s] <= rb_pipe[g][s-1];
            end
        end
    end

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int g = 0; g < NL; g++) begin
            if (clr_mon) begin
                wr_cnt[g]   <= 0;
                addr_err[g] <= 0;
                done_cnt[g] <= 0;
                done_cyc[g] <= -1;
                busy_cnt[g] <= 0;
                for (int i = 0; i < NC; i++) cres[g][i] <= 16'hffff;
            end else begin
                if (c_we_v[g]) begin
                    if (int'(c_addr_v[g]) != wr_cnt[g]) addr_err[g] <= addr_err[g] + 1;
                    wr_cnt[g] <= wr_cnt[g] + 1;
                    cres[g][c_addr_v[g]] <= c_wdata_v[g];
                end
                if (done_v[g]) begin
                    done_cnt[g] <= done_cnt[g] + 1;
                    done_cyc[g] <= edge_cnt - e0;
                end
                if (busy_v[g]) busy_cnt[g] <= busy_cnt[g] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int model(input int a, input int b);
        int m;
        m = (a * b) % KYBER_Q;
        if (m < 0) m += KYBER_Q;
        return (m * R_INV_MOD_Q) % KYBER_Q;
    endfunction

    task automatic clear_mon();
        clr_mon = 1'b1;
        @(negedge clk);
        #1 clr_mon = 1'b0;
    endtask

    task automatic start_op();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        e0 = edge_cnt;
        start = 1'b0;
    endtask

    task automatic wait_cyc(input int k);
        do @(negedge clk); while (edge_cnt - e0 < k);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},    64'(busy_v),    64'd0);
        check({tag, " done"},    64'(done_v),    64'd0);
        check({tag, " a_rd_en"}, 64'(a_rd_en_v), 64'd0);
        check({tag, " b_rd_en"}, 64'(b_rd_en_v), 64'd0);
        check({tag, " a_addr"},  64'(a_addr_v),  64'd0);
        check({tag, " b_addr"},  64'(b_addr_v),  64'd0);
        check({tag, " c_we"},    64'(c_we_v),    64'd0);
        check({tag, " c_addr"},  64'(c_addr_v),  64'd0);
        check({tag, " c_wdata"}, 64'(c_wdata_v), 64'd0);
    endtask

    task automatic check_run(input string tag);
        for (int g = 0; g < NL; g++) begin
            check($sformatf("%s L%0d writes", tag, g + 1),   64'(wr_cnt[g]),   64'(NC));
            check($sformatf("%s L%0d addr_seq", tag, g + 1), 64'(addr_err[g]), 64'd0);
            check($sformatf("%s L%0d done_cnt", tag, g + 1), 64'(done_cnt[g]), 64'd1);
            check($sformatf("%s L%0d done_cyc", tag, g + 1), 64'(done_cyc[g]), 64'(NC + g + 2));
            check($sformatf("%s L%0d busy_cyc", tag, g + 1), 64'(busy_cnt[g]), 64'(NC + g + 2));
        end
    endtask

    task automatic check_results(input string tag);
        for (int g = 0; g < NL; g++)
            for (int i = 0; i < NC; i++)
                check($sformatf("%s L%0d c[%0d]", tag, g + 1, i), 64'(cres[g][i]), 64'(expc[i]));
    endtask

    task automatic full_run(input string tag);
        clear_mon();
        start_op();
        wait_cyc(NC + 9);
        check_run(tag);
        check_results(tag);
    endtask

    initial begin
        vecs[0]  = '{2285,   1,     1};
        vecs[1]  = '{2285,   3328,  3328};
        vecs[2]  = '{1,      1353,  2285};
        vecs[3]  = '{2,      1353,  1241};
        vecs[4]  = '{0,      1234,  0};
        vecs[5]  = '{-2285,  5,     3324};
        vecs[6]  = '{2285,   -1,    3328};
        vecs[7]  = '{3329,   7,     0};
        vecs[8]  = '{1,      1,     169};
        vecs[9]  = '{-1,     1,     3160};
        vecs[10] = '{3328,   3328,  169};
        vecs[11] = '{1353,   1353,  2293};
        vecs[12] = '{-32768, 3328,  1665};
        vecs[13] = '{32767,  3328,  1833};
        vecs[14] = '{32767,  -3328, 1496};
        vecs[15] = '{-3329,  -3329, 0};

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        clr_mon = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        clr_mon = 1'b0;

        // Identity: A = R mod Q gives C = B.
        for (int i = 0; i < NC; i++) begin
            mem_a[i] = 16'(R_MOD_Q);
            mem_b[i] = 16'(i);
            expc[i]  = i;
        end
        full_run("identity");

        // Hand-computed table, zero operands, and conversion into the Montgomery domain.
        for (int i = 0; i < NC; i++) begin
            if (i < 16) begin
                mem_a[i] = 16'(vecs[i].a);
                mem_b[i] = 16'(vecs[i].b);
                expc[i]  = vecs[i].c;
            end else if (i < 128) begin
                mem_a[i] = 16'sd0;
                mem_b[i] = 16'(i);
                expc[i]  = 0;
            end else begin
                mem_a[i] = 16'(i);
                mem_b[i] = 16'(R2_MOD_Q);
                expc[i]  = (i * R_MOD_Q) % KYBER_Q;
            end
        end
        full_run("table");

        // Random signed operands in [-Q, Q].
        for (int i = 0; i < NC; i++) begin
            int a;
            int b;
            a = int'($urandom_range(2 * KYBER_Q, 0)) - KYBER_Q;
            b = int'($urandom_range(2 * KYBER_Q, 0)) - KYBER_Q;
            mem_a[i] = 16'(a);
            mem_b[i] = 16'(b);
            expc[i]  = model(a, b);
        end
        full_run("random");

        // start pulses while busy, and in FIN for the RD_LAT=1 instance, must not restart.
        clear_mon();
        start_op();
        wait_cyc(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(NC + 2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(NC + 6);
        check("restart busy", 64'(busy_v), 64'd0);
        wait_cyc(NC + 9);
        check_run("restart");
        check_results("restart");

        // abort in cycle 50: writes for cycles 1+L..50 survive, nothing after.
        clear_mon();
        start_op();
        wait_cyc(50);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort busy", 64'(busy_v), 64'd0);
        check("abort c_we", 64'(c_we_v), 64'd0);
        check("abort rd_en", 64'(a_rd_en_v), 64'd0);
        wait_cyc(NC + 70);
        for (int g = 0; g < NL; g++) begin
            check($sformatf("abort L%0d writes", g + 1), 64'(wr_cnt[g]), 64'(50 - (g + 1)));
            check($sformatf("abort L%0d done", g + 1),   64'(done_cnt[g]), 64'd0);
        end
        check("abort idle busy", 64'(busy_v), 64'd0);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start+abort busy", 64'(busy_v), 64'd0);
        check("start+abort rd_en", 64'(a_rd_en_v), 64'd0);
        repeat (3) @(negedge clk);
        check("start+abort later busy", 64'(busy_v), 64'd0);
        full_run("after_abort");

        // Asynchronous reset mid-run in cycle 120.
        clear_mon();
        start_op();
        wait_cyc(120);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("mid_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        check("post_reset busy", 64'(busy_v), 64'd0);
        for (int g = 0; g < NL; g++)
            check($sformatf("post_reset L%0d writes", g + 1), 64'(wr_cnt[g]), 64'd0);
        full_run("after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/poly_basemul_ctrl.md
Name: poly_basemul_ctrl

Overview:
- Sequences the shared Montgomery multiplier over a full polynomial: c[i] = a[i]·b[i]·2^-16 mod Q for i = 0..N-1.
- Reads operands from two single-read-port coefficient RAMs (A, B) and writes results to RAM C.
- Streams one coefficient per cycle through the multiplier and registers each result before writeback.
- Sits between the NTT top-level FSM (start/done) and the coefficient memories; used for pointwise scaling and domain conversion.

Parameters:
- N, 256, coefficients per polynomial.
- ADDR_W, 8, address width; ceil(log2(N)).
- RD_LAT, 1, RAM read latency in cycles; legal 1..3.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin; ignored unless idle
- abort  in  1  synchronous cancel; returns to idle, no done pulse
- busy  out  1  high while an operation is in progress
- done  out  1  one-cycle pulse after the last write
- a_rd_en  out  1  read enable, RAM A
- a_addr  out  ADDR_W  read address, RAM A
- a_rdata  in  16  signed coefficient, valid RD_LAT cycles after a_rd_en
- b_rd_en  out  1  read enable, RAM B
- b_addr  out  ADDR_W  read address, RAM B
- b_rdata  in  16  signed coefficient, same timing as A
- c_we  out  1  write enable, RAM C
- c_addr  out  ADDR_W  write address, RAM C
- c_wdata  out  16  result in [0, Q-1]

Behaviour:
- Reset: all outputs 0; FSM = IDLE; counters and pipeline valid bits cleared. Every output is registered.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
  - IDLE: start=1 goes to ISSUE at the next edge; issue counter = 0.
  - ISSUE: a_rd_en = b_rd_en = 1 and a_addr = b_addr = issue counter. The counter increments each cycle. After issuing index N-1, go to DRAIN.
  - DRAIN: no reads. When the last write (index N-1) is on the C port, go to FIN.
  - FIN: done = 1 for exactly one cycle, busy = 0, then IDLE.
- Pipeline and timing:
  - Cycle 0 is the first cycle after the start edge.
  - Index i is issued in cycle i.
  - Its rdata is present in cycle i+RD_LAT and feeds the multiplier combinationally.
  - The product is registered into c_wdata. c_we = 1 and c_addr = i in cycle i+RD_LAT+1.
- Valid/address tracking: a shift register of depth RD_LAT+1 carries the valid bit and the address alongside the data. No gaps; throughput is 1 coefficient/cycle.
- Cycle counts:
  - busy = 1 in cycles 0..N+RD_LAT.
  - done = 1 in cycle N+RD_LAT+1. Defaults give cycle 258.
  - Total latency start→done is N+RD_LAT+2 edges.
- Arithmetic: c_wdata = (a·b·R^-1) mod Q, with R = 2^16 and Q = 3329, always in [0, Q-1]. Inputs are signed 16-bit with |a·b| < Q·2^15.
- Boundary conditions:
  - start while busy or in FIN: ignored, no restart.
  - start and abort asserted together in IDLE: abort wins, stay IDLE.
  - abort in ISSUE or DRAIN: next edge gives IDLE, busy = 0, and all pipeline valid bits are cleared. In-flight writes are dropped (c_we = 0 from that edge) and no done pulse is generated. Writes already completed are not undone.
  - Issue counter at N-1: last issue, no wrap. The address never exceeds N-1.
  - Reset mid-operation: immediate return to the reset state, c_we deasserted asynchronously.
  - RD_LAT outside 1..3: elaboration error.

Decomposition:
- KYBER_Q, KYBER_N and R2_MOD_Q = 1353 (R² mod Q, for test vectors) come from the shared kyber_params include. No new typedefs are needed.
- Sub-module: one montgomery_mul instance for the combinational reduction, with a = a_rdata and b = b_rdata. The controller owns the FSM, counters, valid/address pipeline and the output registers.

Test Plan:
- A[i] = 2285 (R mod Q), B[i] = i, start once → C[i] = i for all i; done in cycle 258; exactly 256 c_we pulses with consecutive addresses 0..255.
- A[i] = B[i] = 0 → C[i] = 0. Also A[i] = i, B[i] = 1353 (R² mod Q) → C[i] = i·R mod Q; check i = 1 gives 2285.
- Random signed A, B in [-Q, Q] compared against the golden model (a·b·169) mod Q. Repeat with RD_LAT = 2 and 3; done must land in cycles 259 and 260.
- start pulsed at cycles 5 and 100 during an operation → no restart; still exactly 256 writes and a single done pulse.
- abort in cycle 50 → busy = 0 next cycle, no further c_we, no done. A new start then completes normally with 256 writes.
- rst_n asserted in cycle 120 → all outputs 0 immediately. After release, idle until start; a full run then completes correctly.
